// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
package vram_arbiter_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned SCR_ADDR_W = 15;
   localparam int unsigned BANK_W     = 3;

   localparam logic [BANK_W-1:0] BANK_SCREEN0 = 3'd5;
   localparam logic [BANK_W-1:0] BANK_SCREEN1 = 3'd7;

   typedef enum logic [2:0] {IDLE, SCR, CPU_RD, CPU_WR, DMA_RD, DMA_WR} arb_state_t;

   function automatic logic state_is_read(input arb_state_t s);
      return (s == SCR) || (s == CPU_RD) || (s == DMA_RD);
   endfunction

   function automatic logic state_is_write(input arb_state_t s);
      return (s == CPU_WR) || (s == DMA_WR);
   endfunction

endpackage

// File: rtl/vram_arbiter_port.sv
// Per-requester bookkeeping: eligibility, completion ack and read-data holding register.
module vram_arbiter_port
   import vram_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              done,
   input  logic              rd,
   input  logic [DATA_W-1:0] din,
   output logic              eligible_c,
   output logic              ack,
   output logic [DATA_W-1:0] rdata
);

   // A port being acked this cycle is not re-granted on the same request.
   assign eligible_c = req && !ack;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack <= done;
         if (done && rd) rdata <= din;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Slot arbiter sharing one external SRAM between screen fetch, Z80 CPU and DMA loader.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned CPU_MAX_WAIT = 6,
   parameter int unsigned ADDR_W       = 19
) (
   input  logic                  clk28,
   input  logic                  rst_n,
   input  logic                  ck14,
   input  logic                  screen_req,
   input  logic                  screen_page,
   input  logic [SCR_ADDR_W-1:0] screen_addr,
   output logic                  screen_fetch_allow,
   output logic [DATA_W-1:0]     screen_data,
   input  logic                  cpu_req,
   input  logic                  cpu_wr,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_ack,
   input  logic                  dma_req,
   input  logic                  dma_wr,
   input  logic [ADDR_W-1:0]     dma_addr,
   input  logic [DATA_W-1:0]     dma_wdata,
   output logic [DATA_W-1:0]     dma_rdata,
   output logic                  dma_ack,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_dout,
   input  logic [DATA_W-1:0]     sram_din,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_drive
);

   localparam int unsigned       WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

   arb_state_t        state, state_d, grant_c;
   logic              phase, phase_d;       // 0: first slot cycle, 1: last slot cycle or free
   logic [WAIT_W-1:0] cpu_wait, cpu_wait_d;
   logic [ADDR_W-1:0] addr_d, scr_phys_c;
   logic [DATA_W-1:0] dout_d, screen_data_d;
   logic              oe_n_d, we_n_d, drive_d;
   logic              decide_c, cpu_elig_c, dma_elig_c, cpu_grant_c;
   logic              scr_unused_c;

   assign decide_c           = ck14 && phase;
   assign scr_phys_c         = ADDR_W'({(screen_page ? BANK_SCREEN1 : BANK_SCREEN0), screen_addr[13:0]});
   assign scr_unused_c       = screen_addr[SCR_ADDR_W-1];
   assign screen_fetch_allow = decide_c && (grant_c == SCR);
   assign cpu_grant_c        = (grant_c == CPU_RD) || (grant_c == CPU_WR);

   vram_arbiter_port u_cpu_port (
      .clk        (clk28),
      .rst_n      (rst_n),
      .req        (cpu_req),
      .done       (phase && ((state == CPU_RD) || (state == CPU_WR))),
      .rd         (state == CPU_RD),
      .din        (sram_din),
      .eligible_c (cpu_elig_c),
      .ack        (cpu_ack),
      .rdata      (cpu_rdata)
   );

   vram_arbiter_port u_dma_port (
      .clk        (clk28),
      .rst_n      (rst_n),
      .req        (dma_req),
      .done       (phase && ((state == DMA_RD) || (state == DMA_WR))),
      .rd         (state == DMA_RD),
      .din        (sram_din),
      .eligible_c (dma_elig_c),
      .ack        (dma_ack),
      .rdata      (dma_rdata)
   );

   // Fixed priority with a starvation guard that lets the CPU past the screen.
   always_comb begin
      grant_c = IDLE;
      if (cpu_elig_c && (cpu_wait == WAIT_MAX)) grant_c = cpu_wr ? CPU_WR : CPU_RD;
      else if (screen_req)                      grant_c = SCR;
      else if (cpu_elig_c)                      grant_c = cpu_wr ? CPU_WR : CPU_RD;
      else if (dma_elig_c)                      grant_c = dma_wr ? DMA_WR : DMA_RD;
   end

   always_comb begin
      state_d       = state;
      phase_d       = 1'b1;
      cpu_wait_d    = cpu_wait;
      addr_d        = sram_addr;
      dout_d        = sram_dout;
      oe_n_d        = sram_oe_n;
      we_n_d        = sram_we_n;
      drive_d       = sram_drive;
      screen_data_d = screen_data;
      if (phase && (state == SCR)) screen_data_d = sram_din;
      if (decide_c) begin
         state_d = grant_c;
         phase_d = 1'b0;
         oe_n_d  = !state_is_read(grant_c);
         we_n_d  = 1'b1;
         drive_d = state_is_write(grant_c);
         case (grant_c)
            SCR:            addr_d = scr_phys_c;
            CPU_RD, CPU_WR: begin addr_d = cpu_addr; dout_d = cpu_wdata; end
            DMA_RD, DMA_WR: begin addr_d = dma_addr; dout_d = dma_wdata; end
            default:        ;
         endcase
         if (cpu_grant_c)
            cpu_wait_d = '0;
         else if (cpu_elig_c && (grant_c == SCR) && (cpu_wait != WAIT_MAX))
            cpu_wait_d = cpu_wait + WAIT_W'(1);
      end else if (!phase) begin
         // Write strobe waits one cycle after address/data for setup.
         we_n_d = !state_is_write(state);
      end else begin
         state_d = IDLE;
         oe_n_d  = 1'b1;
         we_n_d  = 1'b1;
         drive_d = 1'b0;
      end
      if (!cpu_req) cpu_wait_d = '0;
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase       <= 1'b1;
         cpu_wait    <= '0;
         sram_addr   <= '0;
         sram_dout   <= '0;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_drive  <= 1'b0;
         screen_data <= '0;
      end else begin
         state       <= state_d;
         phase       <= phase_d;
         cpu_wait    <= cpu_wait_d;
         sram_addr   <= addr_d;
         sram_dout   <= dout_d;
         sram_oe_n   <= oe_n_d;
         sram_we_n   <= we_n_d;
         sram_drive  <= drive_d;
         screen_data <= screen_data_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter against a slot-booking reference model.
module tb_vram_arbiter;

   localparam int unsigned ADDR_W = 19;
   localparam int          MAXW   = 6;
   localparam int G_IDLE = 0, G_SCR = 1, G_CPU = 2, G_DMA = 3;

   logic              clk28 = 1'b0;
   logic              rst_n, ck14, screen_req, screen_page;
   logic [14:0]       screen_addr;
   logic              screen_fetch_allow;
   logic [7:0]        screen_data;
   logic              cpu_req, cpu_wr, cpu_ack;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata, cpu_rdata;
   logic              dma_req, dma_wr, dma_ack;
   logic [ADDR_W-1:0] dma_addr;
   logic [7:0]        dma_wdata, dma_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_dout, sram_din;
   logic              sram_oe_n, sram_we_n, sram_drive;

   vram_arbiter #(.CPU_MAX_WAIT(MAXW), .ADDR_W(ADDR_W)) dut (
      .clk28(clk28), .rst_n(rst_n), .ck14(ck14),
      .screen_req(screen_req), .screen_page(screen_page), .screen_addr(screen_addr),
      .screen_fetch_allow(screen_fetch_allow), .screen_data(screen_data),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_drive(sram_drive)
   );

   always #18 clk28 = ~clk28;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s at cycle: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected bus picture per cycle, kept in a small ring indexed by cycle number.
   int          n, next_ok, m_wait, allow_cnt;
   logic        e_oe_n[8], e_we_n[8], e_drive[8], e_cack[8], e_dack[8];
   logic        e_addr_v[8], e_dout_v[8], e_cupd[8], e_dupd[8], e_supd[8];
   logic [31:0] e_addr[8], e_dout[8];
   logic [7:0]  din_hist[8];
   logic [7:0]  m_cpu_rdata, m_dma_rdata, m_scr_data;

   task automatic clear_slot(input int i);
      e_oe_n[i] = 1'b1; e_we_n[i] = 1'b1; e_drive[i] = 1'b0;
      e_cack[i] = 1'b0; e_dack[i] = 1'b0; e_addr_v[i] = 1'b0; e_dout_v[i] = 1'b0;
      e_cupd[i] = 1'b0; e_dupd[i] = 1'b0; e_supd[i] = 1'b0;
      e_addr[i] = 0;    e_dout[i] = 0;
   endtask

   // Book a granted slot: bus activity in the two cycles after the decision, completion one later.
   task automatic book(input int g, input logic wr, input int addr, input int wdata);
      int j1, j2, j3;
      j1 = (n + 1) % 8; j2 = (n + 2) % 8; j3 = (n + 3) % 8;
      if (g == G_IDLE) return;
      e_addr_v[j1] = 1'b1; e_addr[j1] = addr;
      e_addr_v[j2] = 1'b1; e_addr[j2] = addr;
      if (wr) begin
         e_drive[j1] = 1'b1; e_drive[j2] = 1'b1; e_we_n[j2] = 1'b0;
         e_dout_v[j1] = 1'b1; e_dout[j1] = wdata;
         e_dout_v[j2] = 1'b1; e_dout[j2] = wdata;
      end else begin
         e_oe_n[j1] = 1'b0; e_oe_n[j2] = 1'b0;
         if (g == G_SCR) e_supd[j3] = 1'b1;
         if (g == G_CPU) e_cupd[j3] = 1'b1;
         if (g == G_DMA) e_dupd[j3] = 1'b1;
      end
      if (g == G_CPU) e_cack[j3] = 1'b1;
      if (g == G_DMA) e_dack[j3] = 1'b1;
   endtask

   // Check the current cycle, advance the model, then move to the next cycle.
   task automatic step();
      int k, g, scr_phys;
      logic decide, cpu_el, dma_el;
      k = n % 8;
      #1;
      if (e_cupd[k]) m_cpu_rdata = din_hist[(n + 7) % 8];
      if (e_dupd[k]) m_dma_rdata = din_hist[(n + 7) % 8];
      if (e_supd[k]) m_scr_data  = din_hist[(n + 7) % 8];
      check_eq("sram_oe_n",   32'(sram_oe_n),   32'(e_oe_n[k]));
      check_eq("sram_we_n",   32'(sram_we_n),   32'(e_we_n[k]));
      check_eq("sram_drive",  32'(sram_drive),  32'(e_drive[k]));
      check_eq("cpu_ack",     32'(cpu_ack),     32'(e_cack[k]));
      check_eq("dma_ack",     32'(dma_ack),     32'(e_dack[k]));
      check_eq("cpu_rdata",   32'(cpu_rdata),   32'(m_cpu_rdata));
      check_eq("dma_rdata",   32'(dma_rdata),   32'(m_dma_rdata));
      check_eq("screen_data", 32'(screen_data), 32'(m_scr_data));
      if (e_addr_v[k]) check_eq("sram_addr", 32'(sram_addr), e_addr[k]);
      if (e_dout_v[k]) check_eq("sram_dout", 32'(sram_dout), e_dout[k]);

      cpu_el = cpu_req && !e_cack[k];
      dma_el = dma_req && !e_dack[k];
      decide = ck14 && (n >= next_ok);
      if (cpu_el && m_wait == MAXW) g = G_CPU;
      else if (screen_req)          g = G_SCR;
      else if (cpu_el)              g = G_CPU;
      else if (dma_el)              g = G_DMA;
      else                          g = G_IDLE;
      if (rst_n) check_eq("fetch_allow", 32'(screen_fetch_allow), 32'(decide && g == G_SCR));
      if (screen_fetch_allow) allow_cnt++;
      din_hist[k] = sram_din;

      if (!rst_n) begin
         for (int j = 1; j <= 3; j++) clear_slot((n + j) % 8);
         e_addr_v[(n + 1) % 8] = 1'b1; e_dout_v[(n + 1) % 8] = 1'b1;
         m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00; m_scr_data = 8'h00;
         m_wait = 0; next_ok = n + 1;
      end else begin
         if (decide) begin
            next_ok  = n + 2;
            scr_phys = (screen_page ? 7 : 5) * 16384 + (int'(screen_addr) % 16384);
            case (g)
               G_SCR:   book(g, 1'b0, scr_phys, 0);
               G_CPU:   book(g, cpu_wr, int'(cpu_addr), int'(cpu_wdata));
               G_DMA:   book(g, dma_wr, int'(dma_addr), int'(dma_wdata));
               default: book(g, 1'b0, 0, 0);
            endcase
            if (g == G_CPU) m_wait = 0;
            else if (g == G_SCR && cpu_el && m_wait < MAXW) m_wait++;
         end
         if (!cpu_req) m_wait = 0;
      end
      clear_slot(k);
      n++;
      @(posedge clk28); #1;
   endtask

   task automatic aligned_ck();
      ck14 = (n % 2 == 0);
   endtask

   task automatic go_to_d();
      aligned_ck();
      if (!ck14) begin step(); aligned_ck(); end
   endtask

   initial begin
      rst_n = 1'b0; ck14 = 1'b0; screen_req = 1'b0; screen_page = 1'b0; screen_addr = 15'h4000;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
      dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = 8'h00; sram_din = 8'h00;
      for (int i = 0; i < 8; i++) begin clear_slot(i); din_hist[i] = 8'h00; end
      e_addr_v[0] = 1'b1; e_dout_v[0] = 1'b1;
      m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00; m_scr_data = 8'h00;
      n = 0; next_ok = 0; m_wait = 0; allow_cnt = 0;
      repeat (2) @(posedge clk28);
      #1;

      repeat (3) begin aligned_ck(); step(); end
      rst_n = 1'b1;
      repeat (2) begin aligned_ck(); step(); end

      // CPU read on an idle bus
      go_to_d();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h12345; sram_din = 8'hA5;
      step(); aligned_ck(); step();
      cpu_req = 1'b0;
      repeat (5) begin aligned_ck(); step(); end

      // CPU write
      go_to_d();
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00001; cpu_wdata = 8'h3C;
      step(); aligned_ck(); step();
      cpu_req = 1'b0;
      repeat (5) begin aligned_ck(); step(); end

      // Screen and CPU both held: starvation guard pattern
      go_to_d();
      screen_req = 1'b1; screen_page = 1'b1; screen_addr = 15'h5800;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00100;
      allow_cnt = 0;
      for (int i = 0; i < 56; i++) begin aligned_ck(); sram_din = 8'($urandom); step(); end
      check_eq("scr_slots_in_28", 32'(allow_cnt), 32'd24);
      screen_req = 1'b0; cpu_req = 1'b0;
      repeat (4) begin aligned_ck(); step(); end

      // CPU and DMA with screen idle: DMA waits for the CPU to go away
      go_to_d();
      cpu_req = 1'b1; cpu_addr = 19'h0ABCD; dma_req = 1'b1; dma_wr = 1'b1;
      dma_addr = 19'h7FFFF; dma_wdata = 8'h5A;
      repeat (20) begin aligned_ck(); step(); end
      cpu_req = 1'b0;
      repeat (8) begin aligned_ck(); step(); end
      dma_req = 1'b0;
      repeat (4) begin aligned_ck(); step(); end

      // Reset in the second cycle of a CPU write
      go_to_d();
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00042; cpu_wdata = 8'hC3;
      step(); aligned_ck(); cpu_req = 1'b0; step();
      aligned_ck(); rst_n = 1'b0; step();
      rst_n = 1'b1;
      repeat (4) begin aligned_ck(); step(); end

      // Random traffic, alternating aligned and misaligned ck14
      for (int i = 0; i < 3000; i++) begin
         if ((i / 128) % 2 == 0) aligned_ck();
         else ck14 = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 7) == 0) screen_req = ~screen_req;
         if ($urandom_range(0, 15) == 0) screen_page = ~screen_page;
         screen_addr = 15'($urandom);
         if (!cpu_req || cpu_ack) begin
            cpu_req = ($urandom_range(0, 2) != 0); cpu_wr = 1'($urandom);
            cpu_addr = ADDR_W'($urandom); cpu_wdata = 8'($urandom);
         end
         if (!dma_req || dma_ack) begin
            dma_req = ($urandom_range(0, 1) != 0); dma_wr = 1'($urandom);
            dma_addr = ADDR_W'($urandom); dma_wdata = 8'($urandom);
         end
         sram_din = 8'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
